move_collector: RTL and testbench



---
 rtl/move_collector.sv | 107 ++++++++++
 tb/tb_move_collector.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_collector.sv
// move_collector: round-robin drain of packed column move FIFOs into one valid/ready move stream.
module move_collector #(
    parameter int NCOL  = 8,
    parameter int MOVEW = 19,
    parameter int SLOTS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NCOL-1:0]             col_done,
    input  logic [NCOL*SLOTS*MOVEW-1:0] col_fifo_out,
    input  logic [NCOL-1:0]             col_fifo_empty,
    output logic [NCOL-1:0]             col_rden,
    output logic [MOVEW-1:0]            move_data,
    output logic                        move_valid,
    input  logic                        move_ready,
    output logic [7:0]                  move_count,
    output logic                        done
);
    localparam int WW = SLOTS * MOVEW;
    localparam int CW = NCOL > 1 ? $clog2(NCOL) : 1;
    localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {SCAN, WAIT, EMIT, DONE} state_t;

    state_t state, state_n;
    logic [CW-1:0] rr_ptr, col, gnt_col;
    logic [SW-1:0] slot;
    logic [WW-1:0] word, col_word;
    logic run, gnt, last, adv;

    function automatic logic [CW-1:0] wrap(input int v);
        return CW'(v % NCOL);
    endfunction

    // The word register shifts left as slots are consumed, so the current slot is always the MSBs.
    assign move_data = word[WW-1 -: MOVEW];
    assign last = slot == SW'(SLOTS - 1);
    assign adv = move_data[MOVEW-1] | move_ready;

    // run holds off the first read until one clock edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SCAN;
            rr_ptr     <= '0;
            col        <= '0;
            slot       <= '0;
            word       <= '0;
            move_count <= '0;
            run        <= 1'b0;
        end else begin
            state <= state_n;
            run   <= 1'b1;
            if (|col_rden)
                col <= gnt_col;
            if (state == WAIT) begin
                word <= col_word;
                slot <= '0;
            end
            if (state == EMIT && adv) begin
                word <= word << MOVEW;
                slot <= slot + 1'b1;
                if (last)
                    rr_ptr <= wrap(int'(col) + 1);
            end
            if (move_valid && move_ready && move_count != 8'hFF)
                move_count <= move_count + 8'd1;
        end
    end

    always_comb begin
        gnt      = 1'b0;
        gnt_col  = '0;
        col_word = '0;
        for (int i = 0; i < NCOL; i++)
            if (!gnt && !col_fifo_empty[wrap(int'(rr_ptr) + i)]) begin
                gnt     = 1'b1;
                gnt_col = wrap(int'(rr_ptr) + i);
            end
        for (int i = 0; i < NCOL; i++)
            if (col == CW'(i))
                col_word = col_fifo_out[i*WW +: WW];
    end

    always_comb begin
        state_n    = state;
        col_rden   = '0;
        move_valid = 1'b0;
        done       = 1'b0;
        case (state)
            SCAN: if (run) begin
                if (gnt) begin
                    col_rden = NCOL'(1) << gnt_col;
                    state_n  = WAIT;
                end else if (&col_done && &col_fifo_empty) begin
                    state_n = DONE;
                end
            end
            WAIT: state_n = EMIT;
            EMIT: begin
                move_valid = !move_data[MOVEW-1];
                if (adv && last)
                    state_n = SCAN;
            end
            DONE: done = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector: random and directed drains checked against a queue-based model of the FIFOs.
module tb_move_collector;
    localparam int NCOL  = 8;
    localparam int MOVEW = 19;
    localparam int SLOTS = 8;
    localparam int WW    = SLOTS * MOVEW;
    localparam int DEPTH = 256;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCOL-1:0]      col_done;
    logic [NCOL*WW-1:0]   col_fifo_out;
    logic [NCOL-1:0]      col_fifo_empty;
    logic [NCOL-1:0]      col_rden;
    logic [MOVEW-1:0]     move_data;
    logic                 move_valid;
    logic                 move_ready = 1'b0;
    logic [7:0]           move_count;
    logic                 done;

    logic [WW-1:0]    mem [NCOL][DEPTH];
    logic [WW-1:0]    q [NCOL];
    int               head [NCOL];
    int               tail [NCOL];
    int               exp_cols [$];
    logic [MOVEW-1:0] exp_moves [$];
    int n_chk = 0, n_err = 0, exp_total = 0, n_acc = 0, rmode = 1;
    int cyc = 0, last_rden = 0, done_cyc = 0;
    logic done_seen = 1'b0;

    move_collector #(.NCOL(NCOL), .MOVEW(MOVEW), .SLOTS(SLOTS)) dut (
        .clk(clk), .reset(reset), .col_done(col_done), .col_fifo_out(col_fifo_out),
        .col_fifo_empty(col_fifo_empty), .col_rden(col_rden), .move_data(move_data),
        .move_valid(move_valid), .move_ready(move_ready), .move_count(move_count), .done(done)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCOL; g++) begin : g_fifo
        assign col_fifo_out[g*WW +: WW] = q[g];
        assign col_fifo_empty[g] = head[g] == tail[g];
    end

    always @(posedge clk)
        for (int k = 0; k < NCOL; k++)
            if (col_rden[k] && head[k] != tail[k]) begin
                q[k]    <= mem[k][head[k]];
                head[k] <= head[k] + 1;
            end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(int k, logic [WW-1:0] w);
        mem[k][tail[k]] = w;
        tail[k]++;
    endtask

    function automatic logic [WW-1:0] rand_word(int pct);
        logic [WW-1:0] w = '0;
        for (int s = 0; s < SLOTS; s++)
            w = {w[WW-MOVEW-1:0], 1'($urandom_range(0, 99) >= pct), 18'($urandom)};
        return w;
    endfunction

    // Walks the FIFO contents in round-robin order from rr, appending expected reads and moves.
    task automatic build_expect(int rr);
        int hd [NCOL];
        int k;
        logic [WW-1:0] w;
        logic [MOVEW-1:0] m;
        for (int i = 0; i < NCOL; i++) hd[i] = head[i];
        for (int n = 0; n < NCOL * DEPTH; n++) begin
            k = -1;
            for (int i = 0; i < NCOL; i++)
                if (k < 0 && hd[(rr + i) % NCOL] != tail[(rr + i) % NCOL]) k = (rr + i) % NCOL;
            if (k < 0) break;
            exp_cols.push_back(k);
            w = mem[k][hd[k]];
            hd[k]++;
            for (int s = 0; s < SLOTS; s++) begin
                m = MOVEW'(w >> ((SLOTS - 1 - s) * MOVEW));
                if (!m[MOVEW-1]) begin
                    exp_moves.push_back(m);
                    exp_total++;
                end
            end
            rr = (k + 1) % NCOL;
        end
    endtask

    initial begin : monitor
        logic hold = 1'b0;
        logic [MOVEW-1:0] hold_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (col_rden != '0) begin
                    check("read_avail", 32'(exp_cols.size() != 0), 32'd1);
                    if (exp_cols.size() != 0) check("read_col", 32'(col_rden), 32'd1 << exp_cols.pop_front());
                    last_rden = cyc;
                end
                if (hold) begin
                    check("hold_valid", 32'(move_valid), 32'd1);
                    check("hold_data", 32'(move_data), 32'(hold_data));
                end
                if (move_valid) check("valid_flag", 32'(move_data[MOVEW-1]), 32'd0);
                if (move_valid && move_ready) begin
                    check("move_avail", 32'(exp_moves.size() != 0), 32'd1);
                    if (exp_moves.size() != 0) check("move_data", 32'(move_data), 32'(exp_moves.pop_front()));
                    n_acc++;
                    hold = 1'b0;
                end else begin
                    hold = move_valid;
                    hold_data = move_data;
                end
                if (done && !done_seen) begin
                    done_seen = 1'b1;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1 move_ready = rmode == 1 ? 1'b1 : rmode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic start_phase();
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_cols.delete();
        exp_moves.delete();
        exp_total = 0;
        n_acc = 0;
        done_seen = 1'b0;
    endtask

    task automatic go();
        build_expect(0);
        reset = 1'b0;
    endtask

    task automatic finish_phase(int timeout);
        for (int i = 0; i < timeout && !done; i++) @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("drained_moves", exp_moves.size(), 32'd0);
        check("drained_reads", exp_cols.size(), 32'd0);
        check("count", 32'(move_count), exp_total > 255 ? 32'd255 : 32'(exp_total));
        repeat (3) @(negedge clk);
        check("done_hold", 32'(done), 32'd1);
        check("idle_valid", 32'(move_valid), 32'd0);
        check("idle_rden", 32'(col_rden), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        col_done = '0;
        #3;
        check("rst_rden", 32'(col_rden), 32'd0);
        check("rst_valid", 32'(move_valid), 32'd0);
        check("rst_count", 32'(move_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // single column, three valid slots followed by five invalid ones
        start_phase();
        push(3, {19'h00A1C, 19'h00B2D, 19'h0053F, {5{19'h40000}}});
        col_done = '1;
        rmode = 1;
        go();
        finish_phase(100);
        check("done_latency", done_cyc - last_rden, SLOTS + 3);

        // columns 0 and 5, then 7 and 2 queued while the pointer sits at 6
        start_phase();
        push(0, rand_word(50));
        push(5, rand_word(50));
        col_done = '0;
        go();
        for (int i = 0; i < 200 && (exp_cols.size() != 0 || exp_moves.size() != 0); i++) @(negedge clk);
        repeat (SLOTS + 4) @(negedge clk);
        check("no_early_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        push(7, rand_word(50));
        push(2, rand_word(50));
        build_expect(6);
        col_done = '1;
        finish_phase(300);

        // downstream stall on a valid slot
        start_phase();
        push(1, {19'h01234, {7{19'h40000}}});
        rmode = 2;
        go();
        for (int i = 0; i < 50 && !move_valid; i++) @(negedge clk);
        check("stall_seen", 32'(move_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(move_valid), 32'd1);
            check("stall_data", 32'(move_data), 32'h01234);
            check("stall_count", 32'(move_count), 32'd0);
        end
        rmode = 1;
        finish_phase(100);

        // random fills with random readiness
        for (int p = 0; p < 3; p++) begin
            start_phase();
            repeat ($urandom_range(0, 12)) push($urandom_range(0, NCOL - 1), rand_word(60));
            rmode = 0;
            go();
            finish_phase(3000);
        end

        // saturation: 320 valid moves
        start_phase();
        repeat (40) push($urandom_range(0, NCOL - 1), rand_word(100));
        rmode = 0;
        go();
        finish_phase(5000);

        // reset while the fifth slot of the first word is on the output
        start_phase();
        push(0, rand_word(100));
        push(0, rand_word(100));
        push(2, rand_word(100));
        rmode = 1;
        go();
        for (int i = 0; i < 100 && n_acc < 4; i++) @(posedge clk);
        #1;
        check("slot4_valid", 32'(move_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_valid", 32'(move_valid), 32'd0);
        check("async_count", 32'(move_count), 32'd0);
        check("async_rden", 32'(col_rden), 32'd0);
        check("async_done", 32'(done), 32'd0);
        start_phase();
        go();
        finish_phase(200);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
